hurricane_ctrl: RTL and testbench

Timing controller for range-hood hurricane (level-3) mode, sitting beside the mode state machine and consuming its mode_state. It decides whether level 3 may be entered and runs the 60 s hurricane countdown. A menu press during level 3 switches to a 60 s exit countdown. When either countdown expires, it drops hurricane_mode_enabled and drives return_state, so the mode state machine leaves level 3 for level 2 or standby.

---
 rtl/hood_pkg.sv | 22 ++
 rtl/sec_tick_gen.sv | 34 +++
 rtl/hurricane_ctrl.sv | 146 ++++++++++++++
 tb/tb_hurricane_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared encodings for the range-hood controllers: mode codes, hurricane
// timer states and the level-3 exit targets.
package hood_pkg;

    localparam logic [2:0] MODE_STANDBY = 3'b000;
    localparam logic [2:0] MODE_L1      = 3'b001;
    localparam logic [2:0] MODE_L2      = 3'b010;
    localparam logic [2:0] MODE_L3      = 3'b011;
    localparam logic [2:0] MODE_CLEAN   = 3'b100;
    localparam logic [2:0] MODE_TIME    = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXIT_CD = 2'd2,
        DONE    = 2'd3
    } hc_state_e;

    localparam logic RET_L2      = 1'b1;
    localparam logic RET_STANDBY = 1'b0;

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ-1 and pulses tick for one cycle
// at the wrap. clr restarts the second from zero.
module sec_tick_gen #(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hurricane_ctrl.sv
// Hurricane (level-3) timer: gates entry to level 3, runs the run and exit
// countdowns, and tells the mode FSM where to go when they expire.
// Build option HURRICANE_REUSE_EN removes the once-per-power-on lockout.
module hurricane_ctrl
    import hood_pkg::*;
#(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int HURRICANE_SEC = 60,
    parameter int EXIT_SEC      = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic [2:0] mode_state,
    input  logic       menu_btn,
    output logic       hurricane_mode_enabled,
    output logic       return_state,
    output logic [7:0] remain_sec,
    output logic       counting
);

`ifdef HURRICANE_REUSE_EN
    localparam logic USE_LOCK = 1'b0;
`else
    localparam logic USE_LOCK = 1'b1;
`endif

    localparam logic [7:0] RUN_LOAD  = 8'(HURRICANE_SEC);
    localparam logic [7:0] EXIT_LOAD = 8'(EXIT_SEC);

    hc_state_e  state_q, state_d;
    logic       used_q, used_d;
    logic       en_q, en_d;
    logic       ret_q, ret_d;
    logic [7:0] remain_q, remain_d;
    logic       counting_q, counting_d;
    logic       menu_prev_q;

    logic menu_rise;
    logic in_l3;
    logic tick;
    logic presc_clr;

    assign menu_rise = menu_btn & ~menu_prev_q;
    assign in_l3     = (mode_state == MODE_L3);

    // Every state change restarts the second, so each countdown step is full length.
    assign presc_clr = (state_d != state_q) | ~machine_state;

    sec_tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (presc_clr),
        .tick(tick)
    );

    always_comb begin
        state_d    = state_q;
        used_d     = used_q;
        en_d       = en_q;
        ret_d      = ret_q;
        remain_d   = remain_q;
        counting_d = counting_q;

        if (!machine_state) begin
            state_d    = IDLE;
            used_d     = 1'b0;
            en_d       = 1'b1;
            ret_d      = RET_STANDBY;
            remain_d   = '0;
            counting_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    en_d = ~used_q;
                    if (in_l3 && !used_q) begin
                        state_d    = RUN;
                        remain_d   = RUN_LOAD;
                        counting_d = 1'b1;
                    end
                end
                RUN, EXIT_CD: begin
                    if (!in_l3) begin
                        state_d    = IDLE;
                        used_d     = USE_LOCK;
                        en_d       = ~USE_LOCK;
                        remain_d   = '0;
                        counting_d = 1'b0;
                    end else if (state_q == RUN && menu_rise) begin
                        // A menu press outranks a coinciding final tick.
                        state_d  = EXIT_CD;
                        remain_d = EXIT_LOAD;
                    end else if (tick) begin
                        if (remain_q == 8'd1) begin
                            state_d    = DONE;
                            remain_d   = '0;
                            counting_d = 1'b0;
                            en_d       = 1'b0;
                            ret_d      = (state_q == RUN) ? RET_L2 : RET_STANDBY;
                        end else begin
                            remain_d = remain_q - 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (!in_l3) begin
                        state_d = IDLE;
                        used_d  = USE_LOCK;
                        en_d    = ~USE_LOCK;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            used_q      <= 1'b0;
            en_q        <= 1'b1;
            ret_q       <= RET_STANDBY;
            remain_q    <= '0;
            counting_q  <= 1'b0;
            menu_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            en_q        <= en_d;
            ret_q       <= ret_d;
            remain_q    <= remain_d;
            counting_q  <= counting_d;
            menu_prev_q <= menu_btn;
        end
    end

    assign hurricane_mode_enabled = en_q;
    assign return_state           = ret_q;
    assign remain_sec             = remain_q;
    assign counting               = counting_q;

endmodule

// File: tb/tb_hurricane_ctrl.sv
// Self-checking bench for hurricane_ctrl with CLK_FREQ=10, HURRICANE_SEC=3,
// EXIT_SEC=2: directed scenarios followed by randomized stimulus.
module tb_hurricane_ctrl;

    localparam int CLK  = 10;
    localparam int HSEC = 3;
    localparam int ESEC = 2;
`ifdef HURRICANE_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       machine_state;
    logic [2:0] mode_state;
    logic       menu_btn;
    logic       hurricane_mode_enabled;
    logic       return_state;
    logic [7:0] remain_sec;
    logic       counting;

    int n_assert = 0;
    int n_fail   = 0;

    hurricane_ctrl #(
        .CLK_FREQ(CLK),
        .HURRICANE_SEC(HSEC),
        .EXIT_SEC(ESEC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .machine_state(machine_state),
        .mode_state(mode_state),
        .menu_btn(menu_btn),
        .hurricane_mode_enabled(hurricane_mode_enabled),
        .return_state(return_state),
        .remain_sec(remain_sec),
        .counting(counting)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 exit countdown, 3 expired.
    // Remaining seconds follow from edges elapsed since the countdown began.
    int m_phase = 0;
    int m_len   = 0;
    int m_el    = 0;
    bit m_used  = 0;
    bit m_en    = 1;
    bit m_ret   = 0;
    bit m_prev  = 0;
    bit m_valid = 0;

    always @(posedge clk) begin
        bit rise;
        rise   = menu_btn && !m_prev;
        m_prev = menu_btn;
        if (rst) begin
            m_phase = 0; m_used = 0; m_en = 1; m_ret = 0; m_prev = 0; m_valid = 1;
        end else if (!machine_state) begin
            m_phase = 0; m_used = 0; m_en = 1; m_ret = 0;
        end else begin
            case (m_phase)
                0: begin
                    m_en = !m_used;
                    if (mode_state == 3'd3 && !m_used) begin
                        m_phase = 1; m_len = HSEC; m_el = 0;
                    end
                end
                1, 2: begin
                    if (mode_state != 3'd3) begin
                        m_phase = 0; m_used = !REUSE; m_en = REUSE;
                    end else if (m_phase == 1 && rise) begin
                        m_phase = 2; m_len = ESEC; m_el = 0;
                    end else if (m_el + 1 == m_len * CLK) begin
                        m_ret = (m_phase == 1); m_phase = 3; m_en = 0;
                    end else begin
                        m_el++;
                    end
                end
                default: begin
                    if (mode_state != 3'd3) begin
                        m_phase = 0; m_used = !REUSE; m_en = REUSE;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int exp_rem;
            exp_rem = (m_phase == 1 || m_phase == 2) ? (m_len - m_el / CLK) : 0;
            chk("model_enabled", int'(hurricane_mode_enabled), int'(m_en));
            chk("model_return_state", int'(return_state), int'(m_ret));
            chk("model_remain_sec", int'(remain_sec), exp_rem);
            chk("model_counting", int'(counting), (m_phase == 1 || m_phase == 2) ? 1 : 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_counting(input string name);
        for (int i = 0; i < 50; i++) begin
            if (counting) return;
            @(negedge clk);
        end
        chk({name, "_timeout"}, int'(counting), 1);
    endtask

    task automatic power_cycle();
        machine_state = 1'b0;
        step(1);
        machine_state = 1'b1;
        step(1);
    endtask

    logic [2:0] other_modes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};

    initial begin
        rst = 1'b1; machine_state = 1'b1; mode_state = 3'd0; menu_btn = 1'b0;
        step(3);
        chk("reset_enabled", int'(hurricane_mode_enabled), 1);
        chk("reset_remain", int'(remain_sec), 0);
        chk("reset_counting", int'(counting), 0);
        chk("reset_return", int'(return_state), 0);
        rst = 1'b0;

        // Natural expiry from level 3 goes back to level 2.
        mode_state = 3'd3;
        wait_counting("s1");
        chk("s1_remain3", int'(remain_sec), 3);
        step(10); chk("s1_remain2", int'(remain_sec), 2);
        step(10); chk("s1_remain1", int'(remain_sec), 1);
        step(10);
        chk("s1_remain0", int'(remain_sec), 0);
        chk("s1_enabled0", int'(hurricane_mode_enabled), 0);
        chk("s1_ret_l2", int'(return_state), 1);
        mode_state = 3'd2; step(2);
        chk("s1_lock_en", int'(hurricane_mode_enabled), REUSE ? 1 : 0);
        mode_state = 3'd3; step(3);
        chk("s1_reenter_counting", int'(counting), REUSE ? 1 : 0);
        chk("s1_reenter_remain", int'(remain_sec), REUSE ? 3 : 0);
        mode_state = 3'd2; step(2);

        // Power cycle clears the lockout; then a menu press starts the exit countdown.
        power_cycle();
        chk("s4_enabled", int'(hurricane_mode_enabled), 1);
        chk("s4_remain0", int'(remain_sec), 0);
        mode_state = 3'd3;
        wait_counting("s4");
        chk("s4_full_run", int'(remain_sec), 3);
        step(10); chk("s2_remain2", int'(remain_sec), 2);
        menu_btn = 1'b1; step(1); menu_btn = 1'b0;
        chk("s2_exit_load", int'(remain_sec), 2);
        chk("s2_exit_counting", int'(counting), 1);
        step(10); chk("s2_exit_remain1", int'(remain_sec), 1);
        menu_btn = 1'b1; step(1); menu_btn = 1'b0;
        chk("s2_menu_ignored", int'(remain_sec), 1);
        step(9);
        chk("s2_enabled0", int'(hurricane_mode_enabled), 0);
        chk("s2_ret_standby", int'(return_state), 0);
        chk("s2_remain0", int'(remain_sec), 0);

        // Menu press on the same cycle as the final run tick.
        mode_state = 3'd2; step(2);
        power_cycle();
        mode_state = 3'd3;
        wait_counting("s3");
        step(29); chk("s3_remain1", int'(remain_sec), 1);
        menu_btn = 1'b1; step(1); menu_btn = 1'b0;
        chk("s3_exit_remain", int'(remain_sec), 2);
        chk("s3_enabled", int'(hurricane_mode_enabled), 1);
        chk("s3_counting", int'(counting), 1);
        step(25);

        // Reset during a run.
        mode_state = 3'd2; step(2);
        power_cycle();
        mode_state = 3'd3;
        wait_counting("s5");
        step(20); chk("s5_remain1", int'(remain_sec), 1);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("s5_rst_enabled", int'(hurricane_mode_enabled), 1);
        chk("s5_rst_remain", int'(remain_sec), 0);
        chk("s5_rst_counting", int'(counting), 0);
        step(1);
        chk("s5_restart", int'(remain_sec), 3);

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            machine_state = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 0) mode_state = 3'd3;
                else mode_state = other_modes[$urandom_range(0, 4)];
            end
            if ($urandom_range(0, 14) == 0) menu_btn = ~menu_btn;
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
